// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer with compare-match and level irq.
// Responds on the core data bus; reads are combinational, writes land on the clock edge.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        irq
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_PSC    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CNT    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CMP    = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(4);

    logic [2:0]  ctrl_q,    ctrl_d;      // {IRQ_EN, AUTO_RELOAD, EN}
    logic [31:0] psc_q,     psc_d;
    logic [31:0] cnt_q,     cnt_d;
    logic [31:0] cmp_q,     cmp_d;
    logic        match_q,   match_d;
    logic [31:0] psc_cnt_q, psc_cnt_d;

    logic             sel;
    logic [IDX_W-1:0] idx;
    logic             wr_en;
    logic             psc_wr;
    logic             tick;
    logic             hit;
    logic             unused_addr;

    // Replace each enabled byte lane of cur with the matching lane of wd.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wd[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign sel         = (addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign idx         = addr[ADDR_W-1:2];
    assign unused_addr = ^addr[1:0];
    assign wr_en       = sel & MemWrite;
    assign psc_wr      = wr_en && (idx == IDX_PSC) && (byte_enable != 4'b0000);
    assign tick        = ctrl_q[0] && !psc_wr && (psc_cnt_q == psc_q);
    assign hit         = tick && (cnt_q == cmp_q);
    assign irq         = match_q & ctrl_q[2];

    // Combinational read mux; zero unless this is a selected load.
    always_comb begin
        r_data = 32'h0;
        if (sel && MemRead) begin
            case (idx)
                IDX_CTRL:   r_data = {29'h0, ctrl_q};
                IDX_PSC:    r_data = psc_q;
                IDX_CNT:    r_data = cnt_q;
                IDX_CMP:    r_data = cmp_q;
                IDX_STATUS: r_data = {31'h0, match_q};
                default:    r_data = 32'h0;
            endcase
        end
    end

    // Next state: hardware counting first, then software writes override it.
    always_comb begin
        ctrl_d    = ctrl_q;
        psc_d     = psc_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        match_d   = match_q;
        psc_cnt_d = 32'h0;

        if (ctrl_q[0] && !psc_wr && !tick) begin
            psc_cnt_d = psc_cnt_q + 32'd1;
        end

        if (tick) begin
            if (hit) begin
                if (ctrl_q[1]) begin
                    cnt_d = 32'h0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (idx)
                IDX_CTRL: begin
                    if (byte_enable[0]) begin
                        ctrl_d = w_data[2:0];
                    end
                end
                IDX_PSC:    psc_d = merge_bytes(psc_q, w_data, byte_enable);
                IDX_CNT:    cnt_d = merge_bytes(cnt_d, w_data, byte_enable);
                IDX_CMP:    cmp_d = merge_bytes(cmp_q, w_data, byte_enable);
                IDX_STATUS: begin
                    if (byte_enable[0] && w_data[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A match on this edge beats a same-edge clear.
        if (hit) begin
            match_d = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= 3'h0;
            psc_q     <= 32'h0;
            cnt_q     <= 32'h0;
            cmp_q     <= 32'h0;
            match_q   <= 1'b0;
            psc_cnt_q <= 32'h0;
        end else begin
            ctrl_q    <= ctrl_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and randomized bus traffic against an in-bench timer model.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [3:0]  byte_enable = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] w_data = 32'h0;
    logic [31:0] r_data;
    logic        irq;

    mmio_timer dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .byte_enable (byte_enable),
        .addr        (addr),
        .w_data      (w_data),
        .r_data      (r_data),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Model state: register file contents plus a count of edges since the last tick.
    logic [2:0]  m_ctrl  = 3'h0;
    logic [31:0] m_psc   = 32'h0;
    logic [31:0] m_cnt   = 32'h0;
    logic [31:0] m_cmp   = 32'h0;
    logic        m_match = 1'b0;
    logic [31:0] m_phase = 32'h0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic        lit_en      = 1'b0;
    logic [31:0] lit_exp     = 32'h0;
    logic        lit_irq_en  = 1'b0;
    logic        lit_irq     = 1'b0;
    string       lit_name    = "";

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        logic [31:0] off;
        if (!rd || (a[31:12] != BASE[31:12])) return 32'h0;
        off = {20'h0, a[11:2], 2'b00};
        case (off)
            32'h00:  return {29'h0, m_ctrl};
            32'h04:  return m_psc;
            32'h08:  return m_cnt;
            32'h0C:  return m_cmp;
            32'h10:  return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the timer, applied rule by rule from the current bus inputs.
    task automatic model_step();
        logic [31:0] off, n_cnt, n_psc, n_cmp_v, n_phase;
        logic [2:0]  n_ctrl;
        logic        n_match, wr, psc_write, is_tick, is_hit;
        wr        = MemWrite && (addr[31:12] == BASE[31:12]);
        off       = {20'h0, addr[11:2], 2'b00};
        psc_write = wr && off == 32'h04 && byte_enable != 4'h0;
        is_tick   = m_ctrl[0] && !psc_write && (m_phase == m_psc);
        is_hit    = is_tick && (m_cnt == m_cmp);
        n_ctrl = m_ctrl; n_psc = m_psc; n_cnt = m_cnt; n_cmp_v = m_cmp; n_match = m_match;
        if (!m_ctrl[0] || psc_write || is_tick) n_phase = 32'h0;
        else n_phase = m_phase + 32'd1;
        if (is_hit && m_ctrl[1]) n_cnt = 32'h0;
        else if (is_hit) n_ctrl[0] = 1'b0;
        else if (is_tick) n_cnt = m_cnt + 32'd1;
        if (wr) begin
            if (off == 32'h00 && byte_enable[0]) n_ctrl = w_data[2:0];
            if (off == 32'h04) n_psc = merge(m_psc, w_data, byte_enable);
            if (off == 32'h08) n_cnt = merge(n_cnt, w_data, byte_enable);
            if (off == 32'h0C) n_cmp_v = merge(m_cmp, w_data, byte_enable);
            if (off == 32'h10 && byte_enable[0] && w_data[0]) n_match = 1'b0;
        end
        if (is_hit) n_match = 1'b1;
        m_ctrl = n_ctrl; m_psc = n_psc; m_cnt = n_cnt; m_cmp = n_cmp_v;
        m_match = n_match; m_phase = n_phase;
    endtask

    // Model process: asynchronous clear, otherwise advance on each rising edge.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_ctrl = 3'h0; m_psc = 32'h0; m_cnt = 32'h0; m_cmp = 32'h0;
            m_match = 1'b0; m_phase = 32'h0;
        end else begin
            model_step();
        end
    end

    // Compare process: every falling edge, DUT vs model, plus any pinned literal.
    initial forever begin
        logic [31:0] exp_r;
        logic        exp_i;
        @(negedge clk);
        exp_r = model_read(MemRead, addr);
        exp_i = m_match & m_ctrl[2];
        n_cmp++;
        if (r_data !== exp_r) begin
            n_err++;
            $display("FAIL model r_data addr=%h got=%h want=%h t=%0t", addr, r_data, exp_r, $time);
        end
        n_cmp++;
        if (irq !== exp_i) begin
            n_err++;
            $display("FAIL model irq got=%b want=%b t=%0t", irq, exp_i, $time);
        end
        if (lit_en) begin
            n_cmp++;
            if (r_data !== lit_exp) begin
                n_err++;
                $display("FAIL %s got=%h want=%h", lit_name, r_data, lit_exp);
            end
        end
        if (lit_irq_en) begin
            n_cmp++;
            if (irq !== lit_irq) begin
                n_err++;
                $display("FAIL %s got=%b want=%b", lit_name, irq, lit_irq);
            end
        end
    end

    task automatic cyc(input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic le, input logic [31:0] lexp, input string name);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; byte_enable = be; addr = a; w_data = wd;
        lit_en = le; lit_exp = lexp; lit_name = name; lit_irq_en = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, be, BASE + off, d, 1'b0, 32'h0, "");
    endtask

    task automatic rd_reg(input logic [31:0] off, input logic [31:0] e, input string name);
        cyc(1'b1, 1'b0, 4'hF, BASE + off, 32'h0, 1'b1, e, name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic irq_chk(input logic e, input string name);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, name);
        lit_irq_en = 1'b1; lit_irq = e;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // Reset mid-operation, then readback of every register.
        wr_reg(32'h0C, 32'h2, 4'hF);
        wr_reg(32'h00, 32'h7, 4'hF);
        idle(6);
        pulse_reset();
        rd_reg(32'h00, 32'h0, "rst_ctrl");
        rd_reg(32'h04, 32'h0, "rst_psc");
        rd_reg(32'h08, 32'h0, "rst_cnt");
        rd_reg(32'h0C, 32'h0, "rst_cmp");
        rd_reg(32'h10, 32'h0, "rst_status");
        irq_chk(1'b0, "rst_irq");

        // Partial byte write.
        wr_reg(32'h0C, 32'hA5A5_A5A5, 4'b0101);
        rd_reg(32'h0C, 32'h00A5_00A5, "cmp_byte_en");

        // Auto-reload.
        wr_reg(32'h04, 32'h0, 4'hF);
        wr_reg(32'h0C, 32'h3, 4'hF);
        wr_reg(32'h08, 32'h0, 4'hF);
        wr_reg(32'h10, 32'h1, 4'hF);
        wr_reg(32'h00, 32'h7, 4'hF);
        rd_reg(32'h08, 32'h0, "ar_cnt0");
        rd_reg(32'h08, 32'h1, "ar_cnt1");
        rd_reg(32'h08, 32'h2, "ar_cnt2");
        rd_reg(32'h08, 32'h3, "ar_cnt3");
        rd_reg(32'h08, 32'h0, "ar_cnt_reload");
        rd_reg(32'h08, 32'h1, "ar_cnt_after");
        rd_reg(32'h10, 32'h1, "ar_match");
        wr_reg(32'h10, 32'h1, 4'h1);
        rd_reg(32'h10, 32'h1, "w1c_collision");
        wr_reg(32'h10, 32'h1, 4'h1);
        irq_chk(1'b0, "irq_drop");
        rd_reg(32'h10, 32'h0, "w1c_cleared");
        wr_reg(32'h00, 32'h0, 4'hF);

        // One-shot with prescale 3.
        wr_reg(32'h04, 32'h2, 4'hF);
        wr_reg(32'h0C, 32'h1, 4'hF);
        wr_reg(32'h08, 32'h0, 4'hF);
        wr_reg(32'h10, 32'h1, 4'hF);
        wr_reg(32'h00, 32'h1, 4'hF);
        rd_reg(32'h08, 32'h0, "os_cnt_j0");
        idle(1);
        rd_reg(32'h08, 32'h0, "os_cnt_j2");
        rd_reg(32'h08, 32'h1, "os_cnt_j3");
        idle(2);
        rd_reg(32'h00, 32'h0, "os_en_cleared");
        rd_reg(32'h08, 32'h1, "os_cnt_hold");
        rd_reg(32'h10, 32'h1, "os_match");

        // Wrap, then a CNT write colliding with a tick.
        wr_reg(32'h04, 32'h0, 4'hF);
        wr_reg(32'h0C, 32'h5, 4'hF);
        wr_reg(32'h08, 32'hFFFF_FFFE, 4'hF);
        wr_reg(32'h10, 32'h1, 4'hF);
        wr_reg(32'h00, 32'h1, 4'hF);
        rd_reg(32'h08, 32'hFFFF_FFFE, "wrap_j0");
        rd_reg(32'h08, 32'hFFFF_FFFF, "wrap_j1");
        rd_reg(32'h08, 32'h0, "wrap_j2");
        rd_reg(32'h08, 32'h1, "wrap_j3");
        wr_reg(32'h08, 32'h10, 4'hF);
        rd_reg(32'h08, 32'h10, "cnt_write_collision");
        rd_reg(32'h08, 32'h11, "cnt_after_collision");
        rd_reg(32'h10, 32'h0, "wrap_no_match");
        wr_reg(32'h00, 32'h0, 4'hF);

        // Decode: outside window and unmapped offsets.
        wr_reg(32'h08, 32'h11, 4'hF);
        cyc(1'b0, 1'b1, 4'hF, BASE + 32'h1008, 32'h1234, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 4'hF, BASE + 32'h1000, 32'h7, 1'b0, 32'h0, "");
        cyc(1'b1, 1'b0, 4'hF, BASE + 32'h1008, 32'h0, 1'b1, 32'h0, "outside_read");
        rd_reg(32'h08, 32'h11, "outside_write_cnt");
        rd_reg(32'h00, 32'h0, "outside_write_ctrl");
        wr_reg(32'h14, 32'hFFFF_FFFF, 4'hF);
        rd_reg(32'h14, 32'h0, "offset_14");

        // PSC rewrite restarts the prescaler.
        wr_reg(32'h04, 32'h3, 4'hF);
        wr_reg(32'h0C, 32'hFFFF, 4'hF);
        wr_reg(32'h08, 32'h0, 4'hF);
        wr_reg(32'h00, 32'h1, 4'hF);
        idle(2);
        wr_reg(32'h04, 32'h3, 4'hF);
        rd_reg(32'h08, 32'h0, "psc_restart_j3");
        idle(2);
        rd_reg(32'h08, 32'h0, "psc_restart_j6");
        rd_reg(32'h08, 32'h1, "psc_restart_j7");
        wr_reg(32'h00, 32'h0, 4'hF);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, wd;
            logic [3:0]  be;
            int unsigned r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                pulse_reset();
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0)      a = BASE + 32'h1000 + ($urandom_range(0, 4) << 2);
                else if (r == 1) a = BASE + ($urandom_range(5, 1023) << 2);
                else             a = BASE + ($urandom_range(0, 4) << 2);
                a  = a | 32'($urandom_range(0, 3));
                wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                cyc(1'($urandom), ($urandom_range(0, 3) == 0), be, a, wd, 1'b0, 32'h0, "");
            end
        end

        idle(3);
        @(posedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
